text_entry_buffer: RTL

- Successor to the single-character switch latch: takes raw push, backspace and clear buttons plus the 8-bit switch value.
- Debounces each button internally and keeps a line of up to DEPTH characters in on-chip memory.
- Exposes a registered read port that the text generation circuit indexes by column, plus status flags and a last-character output for legacy single-character display.

---
 rtl/text_entry_buffer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/text_entry_buffer.sv
// text_entry_buffer: debounced push/backspace/clear editing of a line of up to DEPTH characters, with a column read port.
// Latency: button press to state update 2+DEBOUNCE_CYCLES+1 clk; rd_data follows rd_addr by 1 clk.
// Backpressure: none; button commands that debounce while busy (clear sweep / pending write) are dropped.
//
// Ports:
//   clk, reset       : system clock, synchronous active-low reset
//   btn_push/bksp/clr: raw asynchronous buttons (synchronised + debounced here)
//   switches         : character captured on an accepted push
//   rd_addr, rd_data : column index in, registered character out (FILL_CHAR beyond count)
//   count/empty/full : line occupancy; overflow: sticky dropped-push flag
//   busy             : clear sweep in progress; last_char: last accepted pushed character
module text_entry_buffer #(
    parameter int                DATA_W          = 8,
    parameter int                DEPTH           = 32,
    parameter int                ADDR_W          = 5,
    parameter int                DEBOUNCE_CYCLES = 1000000,
    parameter int                FULL_MODE       = 0,
    parameter logic [DATA_W-1:0] FILL_CHAR       = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_push,
    input  logic              btn_bksp,
    input  logic              btn_clr,
    input  logic [DATA_W-1:0] switches,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic [DATA_W-1:0] last_char
);

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = push, bit 1 = backspace, bit 2 = clear
    // ------------------------------------------------------------------
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       deb_q;
    logic [2:0]       deb_dly_q;
    logic [CNT_W-1:0] dbc_q [3];

    assign btn_raw = {btn_clr, btn_bksp, btn_push};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                // Any sample agreeing with the accepted level restarts the
                // stability window; the level flips on the N-th differing one.
                if (sync2_q[i] == deb_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == CNT_LAST) begin
                    dbc_q[i] <= '0;
                    deb_q[i] <= sync2_q[i];
                end else begin
                    dbc_q[i] <= dbc_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level only; releases are silent.
    logic push_pls;
    logic bksp_pls;
    logic clr_pls;

    assign push_pls = deb_q[0] & ~deb_dly_q[0];
    assign bksp_pls = deb_q[1] & ~deb_dly_q[1];
    assign clr_pls  = deb_q[2] & ~deb_dly_q[2];

    // ------------------------------------------------------------------
    // Line state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [DATA_W-1:0] last_q;
    logic [DATA_W-1:0] last_d;
    logic              pend_vld_q;
    logic              pend_vld_d;
    logic [DATA_W-1:0] pend_dat_q;
    logic [DATA_W-1:0] pend_dat_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;
    logic              is_full;

    assign is_full = (count_q == CNT_FULL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            addr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            last_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        last_d     = last_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        mem_we     = 1'b0;
        mem_waddr  = count_q[ADDR_W-1:0];
        mem_wdat   = switches;

        unique case (state_q)
            ST_IDLE: begin
                // One command per cycle, clear > backspace > push.
                if (clr_pls) begin
                    state_d = ST_CLEAR;
                end else if (bksp_pls) begin
                    if (count_q != '0) begin
                        count_d = count_q - (ADDR_W + 1)'(1);
                    end
                end else if (push_pls) begin
                    if (!is_full) begin
                        mem_we    = 1'b1;
                        mem_waddr = count_q[ADDR_W-1:0];
                        mem_wdat  = switches;
                        count_d   = count_q + (ADDR_W + 1)'(1);
                        last_d    = switches;
                    end else if (FULL_MODE == 0) begin
                        ovf_d = 1'b1;
                    end else begin
                        // Restart the line; the character lands at column 0
                        // once the sweep has finished.
                        pend_vld_d = 1'b1;
                        pend_dat_d = switches;
                        state_d    = ST_CLEAR;
                    end
                end
            end

            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdat  = FILL_CHAR;
                if (addr_q == ADDR_TOP) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    addr_d  = '0;
                    state_d = pend_vld_q ? ST_PEND : ST_IDLE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            ST_PEND: begin
                mem_we     = 1'b1;
                mem_waddr  = '0;
                mem_wdat   = pend_dat_q;
                count_d    = (ADDR_W + 1)'(1);
                last_d     = pend_dat_q;
                pend_vld_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line storage and registered read port
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // No reset on the array: reset always starts a full sweep, and reads
    // past count never expose the stale contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
    end

    // Same-cycle write to the read address returns the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= FILL_CHAR;
        end else if ({1'b0, rd_addr} < count_q) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= FILL_CHAR;
        end
    end

    assign rd_data   = rd_data_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign busy      = (state_q != ST_IDLE);
    assign last_char = last_q;

endmodule
